// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_rx path.
// Holds the receive FSM state encoding, the clock/baud constants that the
// external baud generator and benches use, and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_rx_state_e;

   localparam int CLK_HZ      = 32'd50_000_000;
   localparam int BAUD        = 32'd38400;
   // 50 MHz / 38400 = 1302.08, rounded to the nearest whole cycle.
   localparam int BIT_CYCLES  = (CLK_HZ + (BAUD / 32'd2)) / BAUD;
   localparam int HALF_CYCLES = BIT_CYCLES / 32'd2;

   // XOR of all bits; callers zero-extend narrower data into the 10-bit field.
   function automatic logic calc_parity(input logic [9:0] bits);
      calc_parity = ^bits;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so that an idle (high) line is seen right after reset
// and no spurious falling edge appears when reset releases.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;

   // Two-stage metastability filter, idle-high after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer.
// Detects the start bit on the synchronised line, steers the external baud
// generator through baud_restart, samples each bit on its mid-bit pulse,
// assembles LSB-first frames and hands bytes out over valid/ready with
// framing-error and overrun reporting.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits, parameter PARITY_ODD and output parity_err.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 baud_pulse,
   output logic                 baud_restart,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   logic                 rx_s;
   logic                 rx_d_r;
   uart_rx_state_e       state_r;
   uart_rx_state_e       state_nxt_s;
   logic [3:0]           bit_cnt_r;
   logic [3:0]           bit_cnt_nxt_s;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_nxt_s;
   logic                 stop_bad_r;
   logic                 stop_bad_nxt_s;
   logic                 frame_end_s;
   logic                 frame_fail_s;
   logic                 deliver_s;
`ifdef UART_RX_PARITY_EN
   logic                 parity_bad_r;
   logic                 parity_bad_nxt_s;
   logic                 parity_fail_s;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // Next-state, bit counting and shift-register assembly for the frame.
   always_comb begin
      state_nxt_s    = state_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      shift_nxt_s    = shift_r;
      stop_bad_nxt_s = stop_bad_r;
      frame_end_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_nxt_s = parity_bad_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (rx_d_r && !rx_s) begin
               state_nxt_s    = ST_START;
               bit_cnt_nxt_s  = 4'd0;
               stop_bad_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_pulse) begin
               if (!rx_s) begin
                  state_nxt_s   = ST_DATA;
                  bit_cnt_nxt_s = 4'd0;
               end else begin
                  // Line went back high by mid-start: a glitch, not a frame.
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_DATA: begin
            if (baud_pulse) begin
               shift_nxt_s = {rx_s, shift_r[DATA_BITS-1:1]};
               if (bit_cnt_r == LAST_DATA) begin
                  bit_cnt_nxt_s = 4'd0;
`ifdef UART_RX_PARITY_EN
                  state_nxt_s   = ST_PARITY;
`else
                  state_nxt_s   = ST_STOP;
`endif
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (baud_pulse) begin
               parity_bad_nxt_s = (calc_parity(10'(shift_r)) ^ rx_s) != PARITY_ODD;
               state_nxt_s      = ST_STOP;
               bit_cnt_nxt_s    = 4'd0;
            end else begin
               state_nxt_s = ST_PARITY;
            end
`else
            state_nxt_s = ST_IDLE;
`endif
         end
         ST_STOP: begin
            if (baud_pulse) begin
               stop_bad_nxt_s = stop_bad_r | ~rx_s;
               if (bit_cnt_r == LAST_STOP) begin
                  frame_end_s   = 1'b1;
                  state_nxt_s   = ST_IDLE;
                  bit_cnt_nxt_s = 4'd0;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 4'd1;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Frame verdict at the last stop sample: framing beats parity, else deliver.
   always_comb begin
      deliver_s    = 1'b0;
      frame_fail_s = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_fail_s = 1'b0;
`endif
      if (frame_end_s) begin
         if (stop_bad_nxt_s) begin
            frame_fail_s = 1'b1;
`ifdef UART_RX_PARITY_EN
         end else if (parity_bad_r) begin
            parity_fail_s = 1'b1;
`endif
         end else begin
            deliver_s = 1'b1;
         end
      end else begin
         deliver_s = 1'b0;
      end
   end

   // State register, edge-detect delay and frame assembly registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         rx_d_r     <= 1'b1;
         bit_cnt_r  <= 4'd0;
         shift_r    <= {DATA_BITS{1'b0}};
         stop_bad_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bad_r <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt_s;
         rx_d_r     <= rx_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         shift_r    <= shift_nxt_s;
         stop_bad_r <= stop_bad_nxt_s;
`ifdef UART_RX_PARITY_EN
         parity_bad_r <= parity_bad_nxt_s;
`endif
      end
   end

   // Registered outputs: generator control, busy, error pulses, holding register.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_restart <= 1'b1;
         busy         <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
         rx_data      <= {DATA_BITS{1'b0}};
         rx_valid     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err   <= 1'b0;
`endif
      end else begin
         baud_restart <= (state_nxt_s == ST_IDLE);
         busy         <= (state_nxt_s != ST_IDLE);
         frame_err    <= frame_fail_s;
         overrun_err  <= deliver_s && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
         parity_err   <= parity_fail_s;
`endif
         if (deliver_s && (!rx_valid || rx_ready)) begin
            rx_data  <= shift_r;
            rx_valid <= 1'b1;
         end else if (deliver_s) begin
            // Holding register still owned by the consumer: the new byte is lost.
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end else begin
            rx_valid <= rx_valid;
         end
      end
   end

endmodule
